// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the two-port memory arbiter: FSM states and grant IDs.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    DONE  = 2'b11
  } state_t;

  localparam logic OWNER_D = 1'b0;
  localparam logic OWNER_I = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Two-way round-robin selector: on a tie the port that was not served last wins.
module rr_pick
  import mem_arbiter_pkg::*;
(
  input  logic D_REQ,
  input  logic I_REQ,
  input  logic LAST,
  output logic GRANT_VALID,
  output logic GRANT_ID
);

  assign GRANT_VALID = D_REQ | I_REQ;

  always_comb begin
    GRANT_ID = OWNER_D;
    if (D_REQ && I_REQ) begin
      GRANT_ID = ~LAST;
    end else if (I_REQ) begin
      GRANT_ID = OWNER_I;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one main-memory port between the data cache (read/write) and the
// instruction cache (read-only), one transaction at a time.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              D_READ,
  input  logic              D_WRITE,
  input  logic [ADDR_W-1:0] D_ADDRESS,
  input  logic [DATA_W-1:0] D_WRITEDATA,
  output logic [DATA_W-1:0] D_READDATA,
  output logic              D_BUSYWAIT,
  input  logic              I_READ,
  input  logic [ADDR_W-1:0] I_ADDRESS,
  output logic [DATA_W-1:0] I_READDATA,
  output logic              I_BUSYWAIT,
  output logic              MEM_READ,
  output logic              MEM_WRITE,
  output logic [ADDR_W-1:0] MEM_ADDRESS,
  output logic [DATA_W-1:0] MEM_WRITEDATA,
  input  logic [DATA_W-1:0] MEM_READDATA,
  input  logic              MEM_BUSYWAIT,
  output logic              OWNER
);

  state_t              r_state;
  state_t              w_next_state;
  logic                r_owner;
  logic                r_last;
  logic                r_mem_read;
  logic                r_mem_write;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [DATA_W-1:0]   r_d_rdata;
  logic [DATA_W-1:0]   r_i_rdata;

  logic                w_d_req;
  logic                w_i_req;
  logic                w_grant_valid;
  logic                w_grant_id;
  logic                w_load;
  logic                w_finish;

  assign w_d_req = D_READ | D_WRITE;
  assign w_i_req = I_READ;

  rr_pick u_rr_pick (
    .D_REQ       (w_d_req),
    .I_REQ       (w_i_req),
    .LAST        (r_last),
    .GRANT_VALID (w_grant_valid),
    .GRANT_ID    (w_grant_id)
  );

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:  if (w_grant_valid) w_next_state = ISSUE;
      ISSUE: if (MEM_BUSYWAIT)  w_next_state = WAIT;
      WAIT:  if (!MEM_BUSYWAIT) w_next_state = DONE;
      DONE:  w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Only the owner is ever released; the waiting port keeps stalling.
  always_comb begin
    w_load     = (r_state == IDLE) && w_grant_valid;
    w_finish   = (r_state == WAIT) && !MEM_BUSYWAIT;
    D_BUSYWAIT = w_d_req & ~((r_state == DONE) && (r_owner == OWNER_D));
    I_BUSYWAIT = w_i_req & ~((r_state == DONE) && (r_owner == OWNER_I));
  end

  // A simultaneous read+write from the D port is issued as a write.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_owner     <= OWNER_D;
      r_last      <= OWNER_I;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_d_rdata   <= '0;
      r_i_rdata   <= '0;
    end else begin
      if (w_load) begin
        r_owner    <= w_grant_id;
        r_mem_addr <= (w_grant_id == OWNER_I) ? I_ADDRESS : D_ADDRESS;
        if ((w_grant_id == OWNER_D) && D_WRITE) begin
          r_mem_write <= 1'b1;
          r_mem_read  <= 1'b0;
          r_mem_wdata <= D_WRITEDATA;
        end else begin
          r_mem_write <= 1'b0;
          r_mem_read  <= 1'b1;
        end
      end
      if (w_finish) begin
        r_mem_read  <= 1'b0;
        r_mem_write <= 1'b0;
        r_last      <= r_owner;
        if (!r_mem_write) begin
          if (r_owner == OWNER_I) begin
            r_i_rdata <= MEM_READDATA;
          end else begin
            r_d_rdata <= MEM_READDATA;
          end
        end
      end
    end
  end

  assign D_READDATA    = r_d_rdata;
  assign I_READDATA    = r_i_rdata;
  assign MEM_READ      = r_mem_read;
  assign MEM_WRITE     = r_mem_write;
  assign MEM_ADDRESS   = r_mem_addr;
  assign MEM_WRITEDATA = r_mem_wdata;
  assign OWNER         = r_owner;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a fixed-latency memory model.
module tb_mem_arbiter;

  localparam int N_MEM = 5;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        D_READ = 1'b0;
  logic        D_WRITE = 1'b0;
  logic [5:0]  D_ADDRESS = '0;
  logic [31:0] D_WRITEDATA = '0;
  logic [31:0] D_READDATA;
  logic        D_BUSYWAIT;
  logic        I_READ = 1'b0;
  logic [5:0]  I_ADDRESS = '0;
  logic [31:0] I_READDATA;
  logic        I_BUSYWAIT;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA;
  logic [31:0] MEM_READDATA;
  logic        MEM_BUSYWAIT;
  logic        OWNER;

  logic        m_act = 1'b0;
  logic        m_busy = 1'b0;
  int          m_cnt = 0;
  logic [31:0] m_rdata = '0;
  logic [5:0]  m_waddr = '0;
  logic [31:0] m_wdata = '0;

  int total = 0;
  int bad = 0;

  assign MEM_BUSYWAIT = m_busy;
  assign MEM_READDATA = m_rdata;

  always #5 CLK = ~CLK;

  mem_arbiter #(.ADDR_W(6), .DATA_W(32)) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .D_READ        (D_READ),
    .D_WRITE       (D_WRITE),
    .D_ADDRESS     (D_ADDRESS),
    .D_WRITEDATA   (D_WRITEDATA),
    .D_READDATA    (D_READDATA),
    .D_BUSYWAIT    (D_BUSYWAIT),
    .I_READ        (I_READ),
    .I_ADDRESS     (I_ADDRESS),
    .I_READDATA    (I_READDATA),
    .I_BUSYWAIT    (I_BUSYWAIT),
    .MEM_READ      (MEM_READ),
    .MEM_WRITE     (MEM_WRITE),
    .MEM_ADDRESS   (MEM_ADDRESS),
    .MEM_WRITEDATA (MEM_WRITEDATA),
    .MEM_READDATA  (MEM_READDATA),
    .MEM_BUSYWAIT  (MEM_BUSYWAIT),
    .OWNER         (OWNER)
  );

  // Memory: busy for N_MEM cycles after it first sees a strobe, then idle until the strobe drops.
  always @(posedge CLK) begin
    if (!RESET) begin
      m_act  <= 1'b0;
      m_busy <= 1'b0;
      m_cnt  <= 0;
    end else if (!m_act) begin
      if (MEM_READ || MEM_WRITE) begin
        m_act  <= 1'b1;
        m_busy <= 1'b1;
        m_cnt  <= N_MEM - 1;
        if (MEM_WRITE) begin
          m_waddr <= MEM_ADDRESS;
          m_wdata <= MEM_WRITEDATA;
        end
      end
    end else if (m_busy) begin
      if (m_cnt == 0) m_busy <= 1'b0;
      else            m_cnt  <= m_cnt - 1;
    end else if (!(MEM_READ || MEM_WRITE)) begin
      m_act <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_rel(input logic port_i, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (((port_i ? I_BUSYWAIT : D_BUSYWAIT) == 1'b1) && n < 40);
  endtask

  task automatic wait_strobe(output int n);
    n = 0;
    while (!(MEM_READ || MEM_WRITE) && n < 40) begin
      step();
      n++;
    end
  endtask

  initial begin
    int n;
    logic [31:0] exp_d;
    logic [31:0] exp_i;
    logic        exp_own;
    logic        i_low_seen;

    // Reset held with an I request pending
    RESET  = 1'b0;
    I_READ = 1'b1;
    step();
    step();
    check("rst_mem_read",   32'(MEM_READ),   32'd0);
    check("rst_mem_write",  32'(MEM_WRITE),  32'd0);
    check("rst_owner",      32'(OWNER),      32'd0);
    check("rst_i_busy",     32'(I_BUSYWAIT), 32'd1);
    check("rst_i_rdata",    I_READDATA,      32'h0);
    check("rst_d_rdata",    D_READDATA,      32'h0);
    check("rst_mem_addr",   32'(MEM_ADDRESS), 32'h0);

    // Single I read with a 5-cycle memory
    I_READ = 1'b0;
    RESET  = 1'b1;
    step();
    check("idle_mem_read", 32'(MEM_READ), 32'd0);
    I_READ    = 1'b1;
    I_ADDRESS = 6'h05;
    m_rdata   = 32'hDEADBEEF;
    #1;
    check("rd_busy_same_cycle", 32'(I_BUSYWAIT), 32'd1);
    step();
    check("rd_mem_read",  32'(MEM_READ),    32'd1);
    check("rd_mem_addr",  32'(MEM_ADDRESS), 32'h05);
    check("rd_owner",     32'(OWNER),       32'd1);
    wait_rel(1'b1, n);
    check("rd_release_cycles", 32'(n + 1), 32'd8);
    check("rd_i_rdata",   I_READDATA,       32'hDEADBEEF);
    check("rd_d_rdata",   D_READDATA,       32'h0);
    check("rd_strobe_off", 32'(MEM_READ),   32'd0);
    I_READ = 1'b0;
    step();
    check("rd_idle_busy", 32'(I_BUSYWAIT),  32'd0);

    // Tie right after reset: D write wins, I waits
    RESET = 1'b0;
    step();
    RESET       = 1'b1;
    D_WRITE     = 1'b1;
    D_ADDRESS   = 6'h10;
    D_WRITEDATA = 32'h12345678;
    I_READ      = 1'b1;
    I_ADDRESS   = 6'h02;
    m_rdata     = 32'hCAFEF00D;
    step();
    check("tie_owner",     32'(OWNER),         32'd0);
    check("tie_mem_write", 32'(MEM_WRITE),     32'd1);
    check("tie_mem_read",  32'(MEM_READ),      32'd0);
    check("tie_wdata",     MEM_WRITEDATA,      32'h12345678);
    check("tie_addr",      32'(MEM_ADDRESS),   32'h10);
    i_low_seen = 1'b0;
    n = 0;
    do begin
      step();
      n++;
      if (!I_BUSYWAIT) i_low_seen = 1'b1;
    end while (D_BUSYWAIT && n < 40);
    check("tie_d_release", 32'(n), 32'd7);
    check("tie_i_held",    32'(i_low_seen),    32'd0);
    check("tie_d_rdata",   D_READDATA,         32'h0);
    check("tie_mem_waddr", 32'(m_waddr),       32'h10);
    check("tie_mem_wdata", m_wdata,            32'h12345678);
    D_WRITE = 1'b0;
    step();
    check("tie_gap_i_busy", 32'(I_BUSYWAIT),   32'd1);
    check("tie_gap_strobe", 32'(MEM_READ),     32'd0);
    step();
    check("tie_i_owner",   32'(OWNER),         32'd1);
    check("tie_i_read",    32'(MEM_READ),      32'd1);
    check("tie_i_addr",    32'(MEM_ADDRESS),   32'h02);
    wait_rel(1'b1, n);
    check("tie_i_release", 32'(n), 32'd7);
    check("tie_i_rdata",   I_READDATA,         32'hCAFEF00D);
    I_READ = 1'b0;
    step();

    // Round-robin with both ports requesting continuously
    exp_d     = 32'h0;
    exp_i     = 32'hCAFEF00D;
    D_READ    = 1'b1;
    D_ADDRESS = 6'h21;
    I_READ    = 1'b1;
    I_ADDRESS = 6'h22;
    for (int t = 0; t < 4; t++) begin
      exp_own = (t % 2) == 1;
      m_rdata = 32'hA0000000 + 32'(t);
      wait_strobe(n);
      check("rr_strobe", 32'(MEM_READ), 32'd1);
      check("rr_owner",  32'(OWNER),    32'(exp_own));
      check("rr_addr",   32'(MEM_ADDRESS), exp_own ? 32'h22 : 32'h21);
      wait_rel(exp_own, n);
      check("rr_release", 32'(n), 32'd7);
      if (exp_own) exp_i = m_rdata;
      else         exp_d = m_rdata;
      check("rr_d_rdata", D_READDATA, exp_d);
      check("rr_i_rdata", I_READDATA, exp_i);
    end
    D_READ = 1'b0;
    I_READ = 1'b0;
    step();

    // D read and write together: issued as a write, no capture
    D_READ      = 1'b1;
    D_WRITE     = 1'b1;
    D_ADDRESS   = 6'h30;
    D_WRITEDATA = 32'h55AA55AA;
    m_rdata     = 32'hBADBAD00;
    step();
    check("rw_mem_write", 32'(MEM_WRITE),   32'd1);
    check("rw_mem_read",  32'(MEM_READ),    32'd0);
    check("rw_wdata",     MEM_WRITEDATA,    32'h55AA55AA);
    wait_rel(1'b0, n);
    check("rw_release",   32'(n), 32'd7);
    check("rw_d_rdata",   D_READDATA,       32'hA0000002);
    D_READ  = 1'b0;
    D_WRITE = 1'b0;
    step();

    // Reset while a D read sits in WAIT
    D_READ    = 1'b1;
    D_ADDRESS = 6'h3F;
    m_rdata   = 32'h0F0F0F0F;
    #1;
    check("mr_busy_same_cycle", 32'(D_BUSYWAIT), 32'd1);
    step();
    check("mr_mem_read", 32'(MEM_READ), 32'd1);
    step();
    step();
    RESET = 1'b0;
    step();
    check("mr_rst_read",    32'(MEM_READ),   32'd0);
    check("mr_rst_d_rdata", D_READDATA,      32'h0);
    check("mr_rst_i_rdata", I_READDATA,      32'h0);
    check("mr_rst_owner",   32'(OWNER),      32'd0);
    check("mr_rst_busy",    32'(D_BUSYWAIT), 32'd1);
    RESET = 1'b1;
    step();
    check("mr_regrant_read", 32'(MEM_READ),   32'd1);
    check("mr_regrant_addr", 32'(MEM_ADDRESS), 32'h3F);
    wait_rel(1'b0, n);
    check("mr_release",  32'(n + 1), 32'd8);
    check("mr_d_rdata",  D_READDATA,  32'h0F0F0F0F);
    D_READ = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
